// File: rtl/buzzer_arbiter_if.sv
// Signal bundle between obstacle detection / chip pads and buzzer_arbiter.
// The slave modport is the arbiter's view; master is the driver's view.
interface buzzer_arbiter_if;
  logic [1:0] left_level;
  logic [1:0] right_level;
  logic       tone_en;
  logic       buzzer;
  logic       grant_left;
  logic       grant_right;
  logic       busy;

  modport master (
    output left_level, right_level, tone_en,
    input  buzzer, grant_left, grant_right, busy
  );

  modport slave (
    input  left_level, right_level, tone_en,
    output buzzer, grant_left, grant_right, busy
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Shares one piezo buzzer between left/right obstacle alerts: priority grant with
// round-robin tie-break, fixed-length slots separated by silent gaps, level-coded beeps.
module buzzer_arbiter #(
  parameter int CLK_DIV    = 1000,
  parameter int SLOT_TICKS = 16,
  parameter int GAP_TICKS  = 2
) (
  input  logic            clk,
  input  logic            reset,
  buzzer_arbiter_if.slave bus
);

  localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int PH_MAX = (SLOT_TICKS > GAP_TICKS) ? SLOT_TICKS : GAP_TICKS;
  localparam int PH_W   = ($clog2(PH_MAX) > 3) ? $clog2(PH_MAX) : 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT_L,
    ST_GRANT_R,
    ST_GAP
  } state_e;

  typedef enum logic {
    SIDE_L,
    SIDE_R
  } side_e;

  logic [1:0]      lvl_l_q, lvl_r_q;
  logic [DIV_W-1:0] div_q;
  logic [PH_W-1:0] ph_q, ph_d;
  state_e          state_q, state_d;
  side_e           last_q, last_d;

  logic       tick;
  logic       arb_req;
  side_e      arb_side;
  logic [1:0] own_lvl, oth_lvl;
  logic       slot_end, release_slot;
  logic       granted;
  logic       pattern;

  // NOTE: the level samplers carry no reset; they are overwritten every clock
  // and nothing downstream acts on them while the FSM is held in IDLE.
  always_ff @(posedge clk) begin
    lvl_l_q <= bus.left_level;
    lvl_r_q <= bus.right_level;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      ph_q    <= '0;
      state_q <= ST_IDLE;
      last_q  <= SIDE_R;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      ph_q    <= ph_d;
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  // Higher level wins; equal nonzero levels go to the side not served last.
  assign arb_req = (lvl_l_q != 2'd0) || (lvl_r_q != 2'd0);
  always_comb begin
    if (lvl_l_q != lvl_r_q) begin
      arb_side = (lvl_l_q > lvl_r_q) ? SIDE_L : SIDE_R;
    end else begin
      arb_side = (last_q == SIDE_R) ? SIDE_L : SIDE_R;
    end
  end

  assign own_lvl      = (state_q == ST_GRANT_R) ? lvl_r_q : lvl_l_q;
  assign oth_lvl      = (state_q == ST_GRANT_R) ? lvl_l_q : lvl_r_q;
  assign slot_end     = (ph_q == PH_W'(SLOT_TICKS - 1));
  assign release_slot = slot_end || (own_lvl == 2'd0) ||
                        ((oth_lvl == 2'd3) && (own_lvl != 2'd3));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    last_d  = last_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_req) begin
            state_d = (arb_side == SIDE_L) ? ST_GRANT_L : ST_GRANT_R;
            ph_d    = '0;
            last_d  = arb_side;
          end
        end
        ST_GRANT_L, ST_GRANT_R: begin
          if (release_slot) begin
            state_d = ST_GAP;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (ph_q == PH_W'(GAP_TICKS - 1)) begin
            ph_d = '0;
            if (arb_req) begin
              state_d = (arb_side == SIDE_L) ? ST_GRANT_L : ST_GRANT_R;
              last_d  = arb_side;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Beep cadence follows the live level of the owning side.
  always_comb begin
    pattern = 1'b0;
    case (own_lvl)
      2'd1:    pattern = (ph_q[2:0] < 3'd2);
      2'd2:    pattern = ~ph_q[1];
      2'd3:    pattern = 1'b1;
      default: pattern = 1'b0;
    endcase
  end

  assign granted         = (state_q == ST_GRANT_L) || (state_q == ST_GRANT_R);
  assign bus.buzzer      = granted && pattern && bus.tone_en;
  assign bus.grant_left  = (state_q == ST_GRANT_L);
  assign bus.grant_right = (state_q == ST_GRANT_R);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
